// File: rtl/acg_pkg.sv
// rtl/acg_pkg.sv - shared state encoding and default sizes for the auto clock-gate controller
package acg_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    GATED = 2'd2
  } acg_state_e;

  localparam int ACG_NUM_CH_DEF = 4;
  localparam int ACG_CNT_W_DEF  = 8;
  localparam int ACG_STAT_W_DEF = 16;

endpackage

// File: rtl/acg_channel.sv
// rtl/acg_channel.sv - one gated channel: RUN/IDLE/GATED FSM, idle timer, gate-event counter, optional ICG (ACG_ICG_CELL_EN)
module acg_channel
  import acg_pkg::*;
#(
  parameter int CNT_W  = ACG_CNT_W_DEF,
  parameter int STAT_W = ACG_STAT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_scan_en,
  input  logic              i_glb_en,
  input  logic [CNT_W-1:0]  i_idle_thresh,
  input  logic              i_busy,
  input  logic              i_force_on,
  input  logic              i_cnt_clr,
  output logic              o_icg_en,
  output logic              o_clk,
  output logic              o_gated,
  output logic [STAT_W-1:0] o_gate_cnt
);

  acg_state_e        r_state;
  acg_state_e        w_next;
  logic [CNT_W-1:0]  r_timer;
  logic [CNT_W-1:0]  w_next_timer;
  logic              r_icg_en;
  logic              r_gated;
  logic [STAT_W-1:0] r_gate_cnt;
  logic              w_hold;
  logic              w_gate_evt;

  assign w_hold = i_busy | i_force_on | ~i_glb_en | (i_idle_thresh == '0);

  always_comb begin
    w_next       = r_state;
    w_next_timer = r_timer;
    case (r_state)
      RUN: begin
        if (w_hold) begin
          w_next_timer = '0;
        end else begin
          w_next       = IDLE;
          w_next_timer = CNT_W'(1);
        end
      end
      IDLE: begin
        // threshold compare is live so lowering it mid-count gates at once
        if (w_hold) begin
          w_next       = RUN;
          w_next_timer = '0;
        end else if (r_timer >= i_idle_thresh) begin
          w_next = GATED;
        end else begin
          w_next_timer = r_timer + CNT_W'(1);
        end
      end
      GATED: begin
        if (w_hold) begin
          w_next       = RUN;
          w_next_timer = '0;
        end
      end
      default: begin
        w_next       = RUN;
        w_next_timer = '0;
      end
    endcase
  end

  assign w_gate_evt = (r_state == IDLE) && (w_next == GATED);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= RUN;
      r_timer    <= '0;
      r_icg_en   <= 1'b1;
      r_gated    <= 1'b0;
      r_gate_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_next_timer;
      r_icg_en <= (w_next != GATED);
      r_gated  <= (w_next == GATED);
      if (i_cnt_clr) begin
        r_gate_cnt <= '0;
      end else if (w_gate_evt && (r_gate_cnt != '1)) begin
        r_gate_cnt <= r_gate_cnt + STAT_W'(1);
      end
    end
  end

  assign o_icg_en   = r_icg_en;
  assign o_gated    = r_gated;
  assign o_gate_cnt = r_gate_cnt;

`ifdef ACG_ICG_CELL_EN
  ckgate_cell u_icg (
    .clkin   (i_clk),
    .enable  (r_icg_en),
    .scan_en (i_scan_en),
    .clkout  (o_clk)
  );
`else
  // without the cell the clock passes through; gating is inferred from o_icg_en
  logic w_unused_scan_en;
  assign w_unused_scan_en = i_scan_en;
  assign o_clk            = i_clk;
`endif

endmodule

// File: rtl/auto_clk_gate_ctrl.sv
// rtl/auto_clk_gate_ctrl.sv - NUM_CH independent auto clock-gate channels; ICG cell used when ACG_ICG_CELL_EN is defined
module auto_clk_gate_ctrl
  import acg_pkg::*;
#(
  parameter int NUM_CH = ACG_NUM_CH_DEF,
  parameter int CNT_W  = ACG_CNT_W_DEF,
  parameter int STAT_W = ACG_STAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     scan_en,
  input  logic                     glb_en,
  input  logic [CNT_W-1:0]         idle_thresh,
  input  logic [NUM_CH-1:0]        ch_busy,
  input  logic [NUM_CH-1:0]        ch_force_on,
  input  logic                     cnt_clr,
  output logic [NUM_CH-1:0]        ch_icg_en,
  output logic [NUM_CH-1:0]        ch_clk,
  output logic [NUM_CH-1:0]        ch_gated,
  output logic [NUM_CH*STAT_W-1:0] ch_gate_cnt
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    acg_channel #(
      .CNT_W  (CNT_W),
      .STAT_W (STAT_W)
    ) u_ch (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_scan_en     (scan_en),
      .i_glb_en      (glb_en),
      .i_idle_thresh (idle_thresh),
      .i_busy        (ch_busy[gi]),
      .i_force_on    (ch_force_on[gi]),
      .i_cnt_clr     (cnt_clr),
      .o_icg_en      (ch_icg_en[gi]),
      .o_clk         (ch_clk[gi]),
      .o_gated       (ch_gated[gi]),
      .o_gate_cnt    (ch_gate_cnt[gi*STAT_W +: STAT_W])
    );
  end

endmodule

// File: tb/tb_auto_clk_gate_ctrl.sv
// tb/tb_auto_clk_gate_ctrl.sv - directed self-checking bench for auto_clk_gate_ctrl
module tb_auto_clk_gate_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int STAT_W = 4;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     scan_en;
  logic                     glb_en;
  logic [CNT_W-1:0]         idle_thresh;
  logic [NUM_CH-1:0]        ch_busy;
  logic [NUM_CH-1:0]        ch_force_on;
  logic                     cnt_clr;
  logic [NUM_CH-1:0]        ch_icg_en;
  logic [NUM_CH-1:0]        ch_clk;
  logic [NUM_CH-1:0]        ch_gated;
  logic [NUM_CH*STAT_W-1:0] ch_gate_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  auto_clk_gate_ctrl #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .scan_en     (scan_en),
    .glb_en      (glb_en),
    .idle_thresh (idle_thresh),
    .ch_busy     (ch_busy),
    .ch_force_on (ch_force_on),
    .cnt_clr     (cnt_clr),
    .ch_icg_en   (ch_icg_en),
    .ch_clk      (ch_clk),
    .ch_gated    (ch_gated),
    .ch_gate_cnt (ch_gate_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(ch_gate_cnt[ch*STAT_W +: STAT_W]);
  endfunction

  initial begin
    rstn        = 1'b0;
    scan_en     = 1'b0;
    glb_en      = 1'b1;
    idle_thresh = 8'd4;
    ch_busy     = '1;
    ch_force_on = '0;
    cnt_clr     = 1'b0;
    tick(2);
    check("rst_icg_en", 32'(ch_icg_en), 32'hF);
    check("rst_gated", 32'(ch_gated), 32'h0);
    check("rst_cnt", 32'(ch_gate_cnt), 32'h0);
    rstn = 1'b1;
    tick(2);
    check("clk_pass", 32'(ch_clk), {28'h0, {4{clk}}});

    // threshold gating: idle 4 cycles then gate on the 5th edge
    ch_busy[0] = 1'b0;
    tick(4);
    check("thr_icg_before", 32'(ch_icg_en[0]), 32'h1);
    tick(1);
    check("thr_icg_gated", 32'(ch_icg_en[0]), 32'h0);
    check("thr_gated", 32'(ch_gated[0]), 32'h1);
    check("thr_cnt", cnt(0), 32'h1);
    tick(3);
    check("thr_stay_gated", 32'(ch_gated[0]), 32'h1);
    check("thr_cnt_frozen", cnt(0), 32'h1);

    // wake with 1-cycle latency
    ch_busy[0] = 1'b1;
    tick(1);
    check("wake_icg", 32'(ch_icg_en[0]), 32'h1);
    check("wake_gated", 32'(ch_gated[0]), 32'h0);
    check("wake_cnt", cnt(0), 32'h1);

    // idle interrupt at idle cycle 3 restarts the timer
    ch_busy[1] = 1'b0;
    tick(3);
    ch_busy[1] = 1'b1;
    tick(1);
    check("intr_not_gated", 32'(ch_gated[1]), 32'h0);
    ch_busy[1] = 1'b0;
    tick(4);
    check("intr_restart_icg", 32'(ch_icg_en[1]), 32'h1);
    tick(1);
    check("intr_regate", 32'(ch_icg_en[1]), 32'h0);
    check("intr_cnt", cnt(1), 32'h1);
    ch_busy[1] = 1'b1;
    tick(1);

    // overrides keep channel 2 running
    ch_busy[2]  = 1'b0;
    idle_thresh = 8'd0;
    tick(100);
    check("ovr_thr0_icg", 32'(ch_icg_en[2]), 32'h1);
    idle_thresh = 8'd4;
    glb_en      = 1'b0;
    tick(100);
    check("ovr_glb_icg", 32'(ch_icg_en[2]), 32'h1);
    glb_en         = 1'b1;
    ch_force_on[2] = 1'b1;
    tick(100);
    check("ovr_force_icg", 32'(ch_icg_en[2]), 32'h1);
    check("ovr_cnt", cnt(2), 32'h0);

    // live threshold: lowering below the timer gates on the next edge
    idle_thresh    = 8'd200;
    ch_force_on[2] = 1'b0;
    tick(10);
    check("live_before", 32'(ch_icg_en[2]), 32'h1);
    idle_thresh = 8'd5;
    tick(1);
    check("live_gated", 32'(ch_icg_en[2]), 32'h0);
    check("live_cnt", cnt(2), 32'h1);
    ch_busy[2] = 1'b1;
    tick(1);

    // saturation: 19 more events on channel 0 (20 total) with threshold 1
    idle_thresh = 8'd1;
    for (int i = 0; i < 19; i++) begin
      ch_busy[0] = 1'b0;
      tick(2);
      ch_busy[0] = 1'b1;
      tick(1);
    end
    check("sat_cnt", cnt(0), 32'hF);

    // clear coinciding with IDLE->GATED wins
    ch_busy[0] = 1'b0;
    tick(1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("clr_gated", 32'(ch_gated[0]), 32'h1);
    check("clr_cnt", cnt(0), 32'h0);
    ch_busy[0] = 1'b1;
    tick(1);
    ch_busy[0] = 1'b0;
    tick(2);
    check("clr_then_inc", cnt(0), 32'h1);
    ch_busy[0] = 1'b1;
    tick(1);

    // scan_en does not disturb state or counters
    ch_busy[3] = 1'b0;
    tick(2);
    check("ch3_gated", 32'(ch_gated[3]), 32'h1);
    scan_en = 1'b1;
    tick(3);
    check("scan_gated", 32'(ch_gated[3]), 32'h1);
    check("scan_cnt", cnt(3), 32'h1);
    scan_en = 1'b0;

    // reset while channel 3 is gated
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    check("rst3_icg", 32'(ch_icg_en[3]), 32'h1);
    check("rst3_gated", 32'(ch_gated[3]), 32'h0);
    check("rst3_cnt", cnt(3), 32'h0);
    check("rst_all_cnt", 32'(ch_gate_cnt), 32'h0);
    tick(2);
    check("rst3_regate", 32'(ch_gated[3]), 32'h1);
    check("rst3_regate_cnt", cnt(3), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
